fdd_drive_ctrl: RTL and testbench
=================================

Name: fdd_drive_ctrl

Overview:
- Parametrised successor to the single-drive FDD control logic in the Specialist MX top level.
- Tracks up to NUM_DRIVES disk images downloaded over ioctl: per-drive ready flag and size.
- Decodes the FDD system-register window (drive, side and CPU-hold request) and runs the CPU hold/release handshake against the WD1793, with an optional timeout.
- Presents the selected drive's ready flag, size and SDRAM image base to the wd1793 instance and the RAM address mux.

Parameters:
NUM_DRIVES, 2, number of drive slots (1..8)
DRV_W, 3, width of drive-select field; must satisfy 2**DRV_W >= NUM_DRIVES
ADDR_W, 20, per-image address width; each image occupies 2**ADDR_W bytes
BASE_INDEX, 2, ioctl_index of drive 0; drive i uses BASE_INDEX+i
HOLD_TIMEOUT, 0, maximum hold length in ce ticks; 0 disables the timeout
HOLD_W, 16, width of the timeout counter

Ports:
clk_sys  in  1  system clock (96 MHz); all logic on posedge
reset  in  1  synchronous, active-high
ce  in  1  timeout tick (ce_f1)
ioctl_download  in  1  download in progress
ioctl_index  in  5  download target index
ioctl_addr  in  25  current download byte address
sel  in  1  CPU address in FDD system-register window
wr  in  1  CPU write strobe, level (~cpu_wr_n)
addr  in  2  register select (addrbus[1:0])
din  in  8  CPU write data
dout  out  8  status read-back
fdd_drq  in  1  WD1793 DRQ
fdd_busy  in  1  WD1793 BUSY
cpu_hold  out  1  CPU hold request
fdd_drive  out  DRV_W  selected drive
fdd_side  out  1  selected side
fdd_ready  out  1  selected drive present and loaded
fdd_size  out  ADDR_W+1  selected image size in bytes
fdd_base  out  ADDR_W+DRV_W  SDRAM byte offset of selected image, {fdd_drive, ADDR_W'b0}

Behaviour:
- Write event: we = sel & wr, registered to old_we. Act only on the rising edge (~old_we & we); registers update on that clock edge. A held-high strobe produces exactly one event.
- Register map (write):
  - addr 0: hold request, data ignored.
  - addr 1: clear the sticky timeout flag.
  - addr 2: fdd_side <= din[0].
  - addr 3: fdd_drive <= din[DRV_W-1:0].
- Read map: dout = {tmo, drive padded/truncated to bits[6:4], 1'b0, fdd_side, fdd_ready, cpu_hold} regardless of addr. dout is combinational.
- Hold FSM:
  - IDLE: cpu_hold=0. A write event to addr 0 -> HOLD and clears the timeout counter.
  - HOLD: cpu_hold=1. Condition (fdd_drq | ~fdd_busy) is sampled from the first cycle after entry -> IDLE. Hold therefore lasts at least 1 cycle; release takes effect on the next edge.
  - HOLD with HOLD_TIMEOUT>0: the counter increments on each ce. When it reaches HOLD_TIMEOUT: -> IDLE, tmo <= 1. If release and timeout occur in the same cycle, release wins and tmo is unchanged.
  - Counter saturates at 2**HOLD_W-1.
- Image tracking, drive i, for i < NUM_DRIVES:
  - Registered old_download.
  - Rising edge of ioctl_download with ioctl_index==BASE_INDEX+i: ready[i] <= 0.
  - Falling edge with the same index: ready[i] <= 1, size[i] <= ioctl_addr[ADDR_W-1:0] + 1, computed at ADDR_W+1 bits so a full image gives 2**ADDR_W with no wrap.
  - ioctl_addr bits above ADDR_W are ignored.
  - Indices outside the range are ignored.
- Selected-drive outputs:
  - Valid means fdd_drive < NUM_DRIVES.
  - fdd_ready = valid & ready[fdd_drive].
  - fdd_size = valid ? size[fdd_drive] : 0.
  - fdd_base is always {fdd_drive, zeros}.
  - All three are combinational from registers.
- Reset:
  - cpu_hold=0, FSM=IDLE, counter=0, tmo=0, fdd_side=0, fdd_drive=0, old_we=0.
  - ready[] and size[] are NOT cleared by reset: images persist in SDRAM. Their power-up value is 0 via initial values.
- Reset mid-hold: cpu_hold drops the cycle after reset is sampled.
- Reset mid-download: the download edge is still tracked, because old_download is not reset.

Test Plan:
- Download index 2, last ioctl_addr=0x0C7FF, then drop ioctl_download -> next cycle fdd_ready=1, fdd_size=0x0C800, fdd_base=0. Re-assert download on index 2 -> fdd_ready=0.
- Download index 3 (drive 1), last addr 0xFFFFF. Write addr 3 din=0x01 -> fdd_drive=1, fdd_size=0x100000, fdd_base=0x100000. Write addr 3 din=0x05 -> fdd_ready=0, fdd_size=0.
- fdd_busy=1, fdd_drq=0; write addr 0 -> cpu_hold=1 next cycle. Hold wr high 10 cycles -> still a single event. Pulse fdd_drq -> cpu_hold=0 one cycle later.
- HOLD_TIMEOUT=4, busy stuck high; write addr 0, 4 ce ticks -> cpu_hold=0, dout[7]=1. Write addr 1 -> dout[7]=0.
- Drive 0 loaded, fdd_side=1, cpu_hold=1; assert reset one cycle -> cpu_hold=0, fdd_side=0, fdd_drive=0, fdd_ready still 1.
- Write addr 0 while fdd_busy=0 -> cpu_hold high exactly 1 cycle.

Source files
------------

// File: rtl/fdd_drive_ctrl.sv
// fdd_drive_ctrl: multi-drive FDD image tracking, system-register decode
// and CPU hold/release handshake against the WD1793.
//
// Ports:
//   clk_sys, reset         system clock, synchronous active-high reset
//   ce                     timeout tick
//   ioctl_download/index/addr  image download tracking
//   sel, wr, addr, din     CPU access to the FDD register window
//   dout                   status {tmo, drive[2:0], 0, side, ready, hold}
//   fdd_drq, fdd_busy      WD1793 handshake inputs
//   cpu_hold               CPU hold request
//   fdd_drive, fdd_side    selected drive and side
//   fdd_ready/size/base    selected image state and SDRAM byte offset
module fdd_drive_ctrl #(
  parameter int NUM_DRIVES   = 2,
  parameter int DRV_W        = 3,
  parameter int ADDR_W       = 20,
  parameter int BASE_INDEX   = 2,
  parameter int HOLD_TIMEOUT = 0,
  parameter int HOLD_W       = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    ioctl_download,
  input  logic [4:0]              ioctl_index,
  input  logic [24:0]             ioctl_addr,
  input  logic                    sel,
  input  logic                    wr,
  input  logic [1:0]              addr,
  input  logic [7:0]              din,
  output logic [7:0]              dout,
  input  logic                    fdd_drq,
  input  logic                    fdd_busy,
  output logic                    cpu_hold,
  output logic [DRV_W-1:0]        fdd_drive,
  output logic                    fdd_side,
  output logic                    fdd_ready,
  output logic [ADDR_W:0]         fdd_size,
  output logic [ADDR_W+DRV_W-1:0] fdd_base
);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t state, state_nxt;

  logic              we, old_we, wr_ev;
  logic              wr_hold, wr_clr, wr_side, wr_drv;
  logic              tmo, tmo_set, cnt_clr, tmo_hit, rel;
  logic [HOLD_W-1:0] hold_cnt;
  logic              old_download, dl_rise, dl_fall;
  logic [2:0]        drv3;
  logic              unused_bits;

  // Image state survives reset: images stay in SDRAM.
  logic [NUM_DRIVES-1:0] ready_q = '0;
  logic [ADDR_W:0]       size_q [NUM_DRIVES] = '{default: '0};

  assign we      = sel & wr;
  assign wr_ev   = we & ~old_we;
  assign wr_hold = wr_ev & (addr == 2'd0);
  assign wr_clr  = wr_ev & (addr == 2'd1);
  assign wr_side = wr_ev & (addr == 2'd2);
  assign wr_drv  = wr_ev & (addr == 2'd3);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      old_we    <= 1'b0;
      fdd_side  <= 1'b0;
      fdd_drive <= '0;
    end else begin
      old_we <= we;
      if (wr_side) fdd_side  <= din[0];
      if (wr_drv)  fdd_drive <= din[DRV_W-1:0];
    end
  end

  assign rel     = fdd_drq | ~fdd_busy;
  assign tmo_hit = (HOLD_TIMEOUT != 0) &&
                   (hold_cnt >= HOLD_W'(HOLD_TIMEOUT));

  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_hold  = 1'b0;
    tmo_set   = 1'b0;
    cnt_clr   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (wr_hold) begin
          state_nxt = S_HOLD;
          cnt_clr   = 1'b1;
        end
      end
      S_HOLD: begin
        cpu_hold = 1'b1;
        // Release beats a coincident timeout.
        if (rel) begin
          state_nxt = S_IDLE;
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
          tmo_set   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold_cnt <= '0;
      tmo      <= 1'b0;
    end else begin
      if (cnt_clr)
        hold_cnt <= '0;
      else if (state == S_HOLD && ce &&
               hold_cnt != {HOLD_W{1'b1}})
        hold_cnt <= hold_cnt + 1'b1;
      if (tmo_set)     tmo <= 1'b1;
      else if (wr_clr) tmo <= 1'b0;
    end
  end

  // Edge tracker is not reset so a download spanning reset is seen.
  always_ff @(posedge clk_sys) begin
    old_download <= ioctl_download;
  end

  assign dl_rise = ioctl_download & ~old_download;
  assign dl_fall = ~ioctl_download & old_download;

  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < NUM_DRIVES; i++) begin
      if (ioctl_index == 5'(BASE_INDEX + i)) begin
        if (dl_rise) ready_q[i] <= 1'b0;
        if (dl_fall) begin
          ready_q[i] <= 1'b1;
          size_q[i]  <= {1'b0, ioctl_addr[ADDR_W-1:0]} +
                        {{ADDR_W{1'b0}}, 1'b1};
        end
      end
    end
  end

  // Out-of-range drive numbers match no slot and read as empty.
  always_comb begin
    fdd_ready = 1'b0;
    fdd_size  = '0;
    for (int i = 0; i < NUM_DRIVES; i++) begin
      if (fdd_drive == DRV_W'(i)) begin
        fdd_ready = ready_q[i];
        fdd_size  = size_q[i];
      end
    end
  end

  assign fdd_base = {fdd_drive, {ADDR_W{1'b0}}};

  if (DRV_W >= 3) begin : g_drv_trunc
    assign drv3 = fdd_drive[2:0];
  end else begin : g_drv_pad
    assign drv3 = {{(3-DRV_W){1'b0}}, fdd_drive};
  end

  assign dout = {tmo, drv3, 1'b0, fdd_side, fdd_ready, cpu_hold};

  assign unused_bits = &{1'b0, ioctl_addr[24:ADDR_W], din[7:1]};

endmodule

// File: tb/tb_fdd_drive_ctrl.sv
// tb_fdd_drive_ctrl: directed self-checking bench for fdd_drive_ctrl
// (2 drives, base index 2, 1 MiB images, hold timeout of 4 ticks).
module tb_fdd_drive_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce;
  logic        ioctl_download;
  logic [4:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic        sel, wr;
  logic [1:0]  addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        fdd_drq, fdd_busy;
  logic        cpu_hold;
  logic [2:0]  fdd_drive;
  logic        fdd_side;
  logic        fdd_ready;
  logic [20:0] fdd_size;
  logic [22:0] fdd_base;

  int checks = 0;
  int errors = 0;

  fdd_drive_ctrl #(
    .NUM_DRIVES  (2),
    .DRV_W       (3),
    .ADDR_W      (20),
    .BASE_INDEX  (2),
    .HOLD_TIMEOUT(4),
    .HOLD_W      (16)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ce            (ce),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_addr    (ioctl_addr),
    .sel           (sel),
    .wr            (wr),
    .addr          (addr),
    .din           (din),
    .dout          (dout),
    .fdd_drq       (fdd_drq),
    .fdd_busy      (fdd_busy),
    .cpu_hold      (cpu_hold),
    .fdd_drive     (fdd_drive),
    .fdd_side      (fdd_side),
    .fdd_ready     (fdd_ready),
    .fdd_size      (fdd_size),
    .fdd_base      (fdd_base)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    sel  = 1'b1;
    wr   = 1'b1;
    addr = a;
    din  = d;
    tick();
    sel = 1'b0;
    wr  = 1'b0;
    tick();
  endtask

  task automatic load(input logic [4:0] idx, input logic [24:0] last);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick(2);
    ioctl_addr = last;
    tick();
    ioctl_download = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0;
    ioctl_download = 1'b0; ioctl_index = '0; ioctl_addr = '0;
    sel = 1'b0; wr = 1'b0; addr = '0; din = '0;
    fdd_drq = 1'b0; fdd_busy = 1'b0;
    tick(2);
    chk("rst_hold",  cpu_hold,  0);
    chk("rst_drive", fdd_drive, 0);
    chk("rst_side",  fdd_side,  0);
    chk("rst_ready", fdd_ready, 0);
    chk("rst_size",  fdd_size,  0);
    chk("rst_dout",  dout,      8'h00);
    reset = 1'b0;
    tick();

    // Drive 0, high address bits must be ignored.
    load(5'd2, 25'h100C7FF);
    chk("d0_ready", fdd_ready, 1);
    chk("d0_size",  fdd_size,  21'h0C800);
    chk("d0_base",  fdd_base,  0);
    chk("d0_dout",  dout,      8'h02);
    ioctl_download = 1'b1;
    tick();
    chk("d0_reload_ready", fdd_ready, 0);
    tick();
    ioctl_addr = 25'h0C7FF;
    tick();
    ioctl_download = 1'b0;
    tick();
    chk("d0_again_ready", fdd_ready, 1);

    // Out-of-range indices leave drive 0 untouched.
    load(5'd1, 25'h00010);
    load(5'd10, 25'h00020);
    chk("oor_ready", fdd_ready, 1);
    chk("oor_size",  fdd_size,  21'h0C800);

    // Drive 1, full-size image.
    load(5'd3, 25'h0FFFFF);
    chk("d1_not_sel", fdd_size, 21'h0C800);
    wr_reg(2'd3, 8'h01);
    chk("d1_drive", fdd_drive, 1);
    chk("d1_ready", fdd_ready, 1);
    chk("d1_size",  fdd_size,  21'h100000);
    chk("d1_base",  fdd_base,  23'h100000);
    chk("d1_dout",  dout,      8'h12);
    wr_reg(2'd3, 8'h05);
    chk("d5_ready", fdd_ready, 0);
    chk("d5_size",  fdd_size,  0);
    chk("d5_base",  fdd_base,  23'h500000);
    chk("d5_dout",  dout,      8'h50);
    wr_reg(2'd3, 8'h00);
    wr_reg(2'd2, 8'hFF);
    chk("side1", fdd_side, 1);
    wr_reg(2'd2, 8'hFE);
    chk("side0", fdd_side, 0);

    // Held strobe: one event only.
    fdd_busy = 1'b1;
    sel = 1'b1; wr = 1'b1; addr = 2'd0;
    tick();
    chk("hold_on", cpu_hold, 1);
    tick(9);
    chk("hold_held", cpu_hold, 1);
    fdd_drq = 1'b1;
    tick();
    fdd_drq = 1'b0;
    chk("hold_drq_rel", cpu_hold, 0);
    tick(3);
    chk("hold_single_ev", cpu_hold, 0);
    sel = 1'b0; wr = 1'b0;
    tick();

    // Timeout after 4 ce ticks, busy stuck.
    wr_reg(2'd0, 8'h00);
    chk("tmo_hold_on", cpu_hold, 1);
    ce = 1'b1;
    tick(3);
    chk("tmo_3ticks", cpu_hold, 1);
    tick();
    ce = 1'b0;
    tick();
    chk("tmo_hold_off", cpu_hold, 0);
    chk("tmo_flag", dout[7], 1);
    tick(2);
    chk("tmo_stays_idle", cpu_hold, 0);
    wr_reg(2'd1, 8'h00);
    chk("tmo_clr", dout[7], 0);

    // Release coincident with timeout: tmo stays clear.
    wr_reg(2'd0, 8'h00);
    ce = 1'b1;
    tick(4);
    ce = 1'b0;
    fdd_busy = 1'b0;
    tick();
    chk("race_hold", cpu_hold, 0);
    chk("race_tmo",  dout[7],  0);
    fdd_busy = 1'b1;

    // Reset mid-hold keeps images.
    wr_reg(2'd3, 8'h01);
    wr_reg(2'd2, 8'h01);
    wr_reg(2'd0, 8'h00);
    chk("pre_rst_hold", cpu_hold, 1);
    chk("pre_rst_side", fdd_side, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_hold",  cpu_hold,  0);
    chk("mid_rst_side",  fdd_side,  0);
    chk("mid_rst_drive", fdd_drive, 0);
    chk("mid_rst_ready", fdd_ready, 1);
    chk("mid_rst_size",  fdd_size,  21'h0C800);
    tick();

    // Not busy: hold lasts exactly one cycle.
    fdd_busy = 1'b0;
    sel = 1'b1; wr = 1'b1; addr = 2'd0;
    tick();
    chk("short_hold_on", cpu_hold, 1);
    sel = 1'b0; wr = 1'b0;
    tick();
    chk("short_hold_off", cpu_hold, 0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
